// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester, RAM and status signals of the data-RAM arbiter.
// master is the requester/RAM side, slave is the arbiter side.
interface dmem_arbiter_if #(parameter int WIDTH = 32);
   logic             p0_req, p1_req, p0_we, p1_we;
   logic [1:0]       p0_mode, p1_mode;
   logic [WIDTH-1:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
   logic             p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
   logic [WIDTH-1:0] p0_rdata, p1_rdata;
   logic             mem_we;
   logic [1:0]       mem_mode;
   logic [WIDTH-1:0] mem_addr, mem_din, mem_dout;
   logic             busy;

   modport master (
      output p0_req, p1_req, p0_we, p1_we, p0_mode, p1_mode,
             p0_addr, p1_addr, p0_wdata, p1_wdata, mem_dout,
      input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
             mem_we, mem_mode, mem_addr, mem_din, busy
   );

   modport slave (
      input  p0_req, p1_req, p0_we, p1_we, p0_mode, p1_mode,
             p0_addr, p1_addr, p0_wdata, p1_wdata, mem_dout,
      output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
             mem_we, mem_mode, mem_addr, mem_din, busy
   );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serialises CPU (port 0) and debug (port 1) accesses onto one single-port data RAM.
// Define DMEM_ARB_STARVE_GUARD_EN to let port 1 win after MAX_WAIT consecutive port-0 grants.
module dmem_arbiter #(
   parameter int WIDTH    = 32,
   parameter int LATENCY  = 1,
   parameter int MAX_WAIT = 4
) (
   input logic           clk,
   input logic           rst,
   dmem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);
   state_t           state, state_nx;
   logic             owner, we_q, idle, guard, sel0, sel1;
   logic [1:0]       mode_q, cnt;
   logic [WIDTH-1:0] addr_q, wdata_q, rdata;

   if (LATENCY < 1 || LATENCY > 4 || MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_cfg
      $error("dmem_arbiter: LATENCY must be 1..4 and MAX_WAIT 1..15");
   end

   // grants stay low while reset is held even though the FSM sits in IDLE
   assign idle = rst && state == IDLE;
   assign sel1 = idle && bus.p1_req && (!bus.p0_req || guard);
   assign sel0 = idle && bus.p0_req && !sel1;

`ifdef DMEM_ARB_STARVE_GUARD_EN
   logic [3:0] wcnt;
   assign guard = bus.p1_req && wcnt == 4'(MAX_WAIT);
   always_ff @(posedge clk or negedge rst)
      if (!rst) wcnt <= '0;
      else if (idle) wcnt <= (sel1 || !bus.p1_req) ? 4'd0 : (sel0 && wcnt != 4'(MAX_WAIT)) ? wcnt + 4'd1 : wcnt;
`else
   assign guard = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = (sel0 || sel1) ? ACCESS : IDLE;
         ACCESS:  state_nx = cnt == '0 ? RESP : ACCESS;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         owner   <= 1'b0;
         we_q    <= 1'b0;
         mode_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt     <= '0;
         rdata   <= '0;
      end else if (sel0 || sel1) begin
         owner   <= sel1;
         we_q    <= sel1 ? bus.p1_we : bus.p0_we;
         mode_q  <= sel1 ? bus.p1_mode : bus.p0_mode;
         addr_q  <= sel1 ? bus.p1_addr : bus.p0_addr;
         wdata_q <= sel1 ? bus.p1_wdata : bus.p0_wdata;
         cnt     <= CNT_INIT;
      end else if (state == ACCESS) begin
         cnt <= cnt - 2'd1;
         if (cnt == '0) rdata <= bus.mem_dout;
      end

   assign bus.p0_gnt    = sel0;
   assign bus.p1_gnt    = sel1;
   assign bus.p0_rvalid = state == RESP && !owner;
   assign bus.p1_rvalid = state == RESP && owner;
   assign bus.p0_rdata  = rdata;
   assign bus.p1_rdata  = rdata;
   // cnt still holds its load value only in the first ACCESS cycle: one pulse per store
   assign bus.mem_we    = state == ACCESS && we_q && cnt == CNT_INIT;
   assign bus.mem_mode  = mode_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_din   = wdata_q;
   assign bus.busy      = state != IDLE;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized bench for dmem_arbiter, checked every cycle
// against a timeline model (grant cycle G -> write at G+1, capture at G+L, rvalid at G+L+1).
module tb_dmem_arbiter;
   localparam int W = 32, LAT = 3, MW = 2;
`ifdef DMEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b0;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.WIDTH(W)) bus ();
   dmem_arbiter #(.WIDTH(W), .LATENCY(LAT), .MAX_WAIT(MW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0, errors = 0, cyc = 0;
   logic [W-1:0] ram [16] = '{default: '0};
   logic [W-1:0] mram [16] = '{default: '0};
   logic         force_en = 1'b0;
   logic [W-1:0] force_val = '0;

   // RAM output changes every cycle so early or late capture is visible
   always @(posedge clk) cyc <= cyc + 1;
   assign bus.mem_dout = force_en ? force_val : ram[bus.mem_addr[5:2]] + W'(cyc);
   always @(posedge clk) if (bus.mem_we) ram[bus.mem_addr[5:2]] <= bus.mem_din;

   task automatic chk1(input string nm, input logic a, input logic e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %b, want %b (cycle %0d)", nm, a, e, cyc);
      end
   endtask

   task automatic chkw(input string nm, input logic [W-1:0] a, input logic [W-1:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, a, e, cyc);
      end
   endtask

   int free_at = 0, we_at = -1, cap_at = -1, rv_at = -1, w = 0;
   bit t_port, t_we;
   logic [1:0]   l_mode = '0;
   logic [W-1:0] l_addr = '0, l_din = '0, exp_rd = '0;

   always @(negedge clk) begin : cmp
      bit idle, e0, e1;
      if (!rst) begin
         chk1("rst_p0_gnt", bus.p0_gnt, 1'b0);
         chk1("rst_p1_gnt", bus.p1_gnt, 1'b0);
         chk1("rst_p0_rvalid", bus.p0_rvalid, 1'b0);
         chk1("rst_p1_rvalid", bus.p1_rvalid, 1'b0);
         chk1("rst_mem_we", bus.mem_we, 1'b0);
         chk1("rst_busy", bus.busy, 1'b0);
         chkw("rst_mem_addr", bus.mem_addr, '0);
         chkw("rst_mem_din", bus.mem_din, '0);
         chkw("rst_mem_mode", W'(bus.mem_mode), '0);
         chkw("rst_rdata", bus.p0_rdata, '0);
         free_at = 0; we_at = -1; cap_at = -1; rv_at = -1; w = 0;
         l_addr = '0; l_din = '0; l_mode = '0; exp_rd = '0;
      end else begin
         idle = cyc >= free_at;
         e1 = idle && bus.p1_req && (!bus.p0_req || (GUARD && w == MW));
         e0 = idle && bus.p0_req && !e1;
         chk1("p0_gnt", bus.p0_gnt, e0);
         chk1("p1_gnt", bus.p1_gnt, e1);
         chk1("busy", bus.busy, !idle);
         chk1("mem_we", bus.mem_we, cyc == we_at && t_we);
         chkw("mem_addr", bus.mem_addr, l_addr);
         chkw("mem_din", bus.mem_din, l_din);
         chkw("mem_mode", W'(bus.mem_mode), W'(l_mode));
         chk1("p0_rvalid", bus.p0_rvalid, cyc == rv_at && !t_port);
         chk1("p1_rvalid", bus.p1_rvalid, cyc == rv_at && t_port);
         if (cyc == rv_at && !t_we) begin
            chkw("p0_rdata", bus.p0_rdata, exp_rd);
            chkw("p1_rdata", bus.p1_rdata, exp_rd);
         end
         if (cyc == cap_at) exp_rd = force_en ? force_val : mram[l_addr[5:2]] + W'(cyc);
         if (cyc == we_at && t_we) mram[l_addr[5:2]] = l_din;
         if (idle) w = (e1 || !bus.p1_req) ? 0 : (e0 && w < MW) ? w + 1 : w;
         if (e0 || e1) begin
            t_port = e1;
            t_we   = e1 ? bus.p1_we : bus.p0_we;
            l_addr = e1 ? bus.p1_addr : bus.p0_addr;
            l_din  = e1 ? bus.p1_wdata : bus.p0_wdata;
            l_mode = e1 ? bus.p1_mode : bus.p0_mode;
            we_at = cyc + 1; cap_at = cyc + LAT; rv_at = cyc + LAT + 1; free_at = cyc + LAT + 2;
         end
      end
   end

   int g0c, g1c, r0c, r1c, nwe, nhit, n1g, n1r, ngr;
   logic [W-1:0] we_a, we_d, rd0;
   logic [5:0]   seq;

   task automatic clear();
      g0c = -1; g1c = -1; r0c = -1; r1c = -1;
      nwe = 0; nhit = 0; n1g = 0; n1r = 0; ngr = 0;
      we_a = '0; we_d = '0; rd0 = '0; seq = '0;
   endtask

   task automatic watch(input int n, input bit drop0, input bit drop1);
      bit s0, s1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk); #1;
         s0 = bus.p0_gnt; s1 = bus.p1_gnt;
         if (s0 && g0c < 0) g0c = cyc;
         if (s1 && g1c < 0) g1c = cyc;
         if (bus.p0_rvalid) begin r0c = cyc; rd0 = bus.p0_rdata; end
         if (bus.p1_rvalid) begin r1c = cyc; n1r++; end
         if (s1) n1g++;
         if (bus.mem_we) begin nwe++; we_a = bus.mem_addr; we_d = bus.mem_din; end
         if (bus.busy && !bus.p0_rvalid && !bus.p1_rvalid && bus.mem_addr == 32'h10) nhit++;
         if ((s0 || s1) && ngr < 6) begin seq[ngr] = s1; ngr++; end
         @(posedge clk); #1;
         if (s0 && drop0) bus.p0_req = 1'b0;
         if (s1 && drop1) bus.p1_req = 1'b0;
      end
   endtask

   initial begin
      bit s0, s1;
      {bus.p0_req, bus.p1_req, bus.p0_we, bus.p1_we} = '0;
      {bus.p0_mode, bus.p1_mode} = '0;
      {bus.p0_addr, bus.p1_addr, bus.p0_wdata, bus.p1_wdata} = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      clear();
      force_en = 1'b1; force_val = 32'hDEADBEEF;
      bus.p0_we = 1'b0; bus.p0_addr = 32'h10; bus.p0_mode = 2'b10; bus.p0_req = 1'b1;
      watch(8, 1'b1, 1'b1);
      force_en = 1'b0;
      chkw("load_latency", W'(r0c - g0c), 32'd4);
      chkw("load_rdata", rd0, 32'hDEADBEEF);
      chkw("load_addr_cycles", W'(nhit), 32'd3);

      clear();
      bus.p1_we = 1'b1; bus.p1_addr = 32'h20; bus.p1_wdata = 32'hA5; bus.p1_mode = 2'b10; bus.p1_req = 1'b1;
      watch(8, 1'b1, 1'b1);
      chkw("store_we_pulses", W'(nwe), 32'd1);
      chkw("store_din", we_d, 32'hA5);
      chkw("store_addr", we_a, 32'h20);
      chkw("store_latency", W'(r1c - g1c), 32'd4);

      clear();
      bus.p0_we = 1'b0; bus.p0_addr = 32'h44; bus.p1_we = 1'b0; bus.p1_addr = 32'h48;
      bus.p0_req = 1'b1; bus.p1_req = 1'b1;
      watch(12, 1'b1, 1'b1);
      chkw("contention_p1_after_p0", W'(g1c - g0c), 32'd5);

      clear();
      bus.p0_req = 1'b1; bus.p1_req = 1'b1;
      watch(32, 1'b0, 1'b0);
      bus.p0_req = 1'b0; bus.p1_req = 1'b0;
      chkw("starve_grants", W'(ngr), 32'd6);
      chkw("starve_seq", W'(seq), GUARD ? 32'b100100 : 32'b0);
      repeat (6) @(posedge clk);
      #1;

      clear();
      bus.p0_addr = 32'h10; bus.p0_req = 1'b1;
      watch(1, 1'b1, 1'b0);
      bus.p1_req = 1'b1;
      @(posedge clk); #1;
      bus.p1_req = 1'b0;
      watch(10, 1'b1, 1'b1);
      chkw("withdrawn_p1_gnt", W'(n1g), 32'd0);
      chkw("withdrawn_p1_rvalid", W'(n1r), 32'd0);

      clear();
      bus.p1_we = 1'b1; bus.p1_addr = 32'h30; bus.p1_wdata = 32'h12345678; bus.p1_req = 1'b1;
      watch(1, 1'b0, 1'b1);
      #1;
      chk1("pre_reset_we", bus.mem_we, 1'b1);
      rst = 1'b0;
      #1;
      chk1("reset_busy_now", bus.busy, 1'b0);
      chk1("reset_we_now", bus.mem_we, 1'b0);
      chk1("reset_gnt_now", bus.p0_gnt | bus.p1_gnt, 1'b0);
      chk1("reset_rvalid_now", bus.p0_rvalid | bus.p1_rvalid, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      chk1("post_reset_busy", bus.busy, 1'b0);
      watch(6, 1'b1, 1'b1);
      chkw("aborted_store_ram", ram[12], 32'h0);
      chkw("aborted_store_rvalid", W'(n1r), 32'd0);

      for (int i = 0; i < 3000; i++) begin
         @(negedge clk); #1;
         s0 = bus.p0_gnt; s1 = bus.p1_gnt;
         @(posedge clk); #1;
         if (!bus.p0_req || s0) begin
            bus.p0_req = $urandom_range(0, 3) != 0;
            bus.p0_we = 1'($urandom_range(0, 1));
            bus.p0_mode = 2'($urandom_range(0, 3));
            bus.p0_addr = $urandom();
            bus.p0_wdata = $urandom();
         end else if ($urandom_range(0, 15) == 0) bus.p0_req = 1'b0;
         if (!bus.p1_req || s1) begin
            bus.p1_req = $urandom_range(0, 1) != 0;
            bus.p1_we = 1'($urandom_range(0, 1));
            bus.p1_mode = 2'($urandom_range(0, 3));
            bus.p1_addr = $urandom();
            bus.p1_wdata = $urandom();
         end else if ($urandom_range(0, 31) == 0) bus.p1_req = 1'b0;
      end
      bus.p0_req = 1'b0; bus.p1_req = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
